bisr_session_ctrl: RTL
======================

BISR_SESSION_CTRL -- requirements
Module: bisr_session_ctrl

Interface
REQ-001 Parameters SHALL be: ROWS, default `ROWS, array rows; COLS, default `COLS, array columns; WORD_SIZE, default `WORD_SIZE, datapath width; LOAD_CYCLES, default ROWS, cycles between start_fsm and start_matmul; TIMEOUT, default 1024, max wait cycles per stage; TEST_PERIOD, default 8, jobs between self-tests.
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- job_req  in  1  matmul job requested.
- inputs_rdy  in  1  input matrices resident in memory.
- force_test  in  1  run self-test before the next job regardless of period.
- job_ack  out  1  one-cycle pulse, job accepted.
- STW_test_load_en  out  1  load STW operands into array.
- STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected  out  WORD_SIZE each  STW operands.
- STW_start  out  1  one-cycle pulse, start STW.
- STW_complete  in  1  STW finished.
- STW_result_mat  in  ROWS*COLS  per-PE fault flags, bit r*COLS+c, 1 = faulty.
- start_fsm  out  1  one-cycle pulse to matmul FSM.
- start_matmul  out  1  one-cycle pulse to matmul FSM.
- matmul_output_done  in  1  output matrix complete.
- fault_map  out  ROWS*COLS  last captured STW result.
- col_fault_cnt_max  out  $clog2(ROWS+1)  highest faulty-PE count in any column.
- busy  out  1  state != IDLE.
- job_done  out  1  one-cycle pulse, job finished.
- err  out  2  sticky code: 0 none, 1 STW timeout, 2 unrepairable, 3 matmul timeout.

Function
REQ-003 States SHALL be IDLE, STW_LOAD, STW_RUN, STW_CHECK, MM_FSM, MM_LOAD, MM_RUN, DONE, ERR.
REQ-004 IDLE: when job_req & inputs_rdy, pulse job_ack that cycle; go to STW_LOAD if force_test was latched, job_cnt == 0, or fault_map never captured since reset; else go to MM_FSM.
REQ-005 force_test SHALL be latched in any state, cleared on entry to STW_LOAD.
REQ-006 STW_LOAD: assert STW_test_load_en for exactly one cycle with package constant operands driven, then go to STW_RUN.
REQ-007 STW_RUN: pulse STW_start on the first cycle; wait for STW_complete; wait counter starts at 0 on entry; if the counter reaches TIMEOUT with no STW_complete, go to ERR with err=1.
REQ-008 On STW_complete, capture STW_result_mat into fault_map on the same edge, then go to STW_CHECK.
REQ-009 STW_CHECK: compute per-column popcount and register its maximum in col_fault_cnt_max (one cycle); if the value exceeds 1 (one weight proxy per column), go to ERR with err=2; else go to MM_FSM.
REQ-010 MM_FSM: pulse start_fsm for one cycle, then go to MM_LOAD.
REQ-011 MM_LOAD: count LOAD_CYCLES cycles, then pulse start_matmul and go to MM_RUN; start_matmul SHALL occur exactly LOAD_CYCLES+1 cycles after start_fsm.
REQ-012 MM_RUN: wait for matmul_output_done; TIMEOUT exceeded goes to ERR with err=3.
REQ-013 DONE: pulse job_done for one cycle; job_cnt increments modulo TEST_PERIOD; return to IDLE.
REQ-014 ERR: stay there with busy=1; ignore job_req; exit only via reset.
REQ-015 job_req while busy SHALL be ignored, with no ack and no queueing.
REQ-016 STW_complete or matmul_output_done arriving in any state other than its wait state SHALL be ignored.
REQ-017 Only one of STW_start, start_fsm and start_matmul SHALL be high in any cycle.

Reset
REQ-018 When rst=0, asynchronously set state=IDLE and clear all pulses, STW_test_load_en, fault_map, col_fault_cnt_max, err, job_cnt, the force latch, the "captured" flag and the wait counter; operand outputs stay at their constants.
REQ-019 Reset asserted mid-job SHALL abort the job with no job_done; operation resumes on the first clk edge after rst rises.

Structure
REQ-020 STW operand constants, the state enum and the err code enum SHALL live in a shared package (bisr_ctrl_pkg).
REQ-021 Per-column popcount/max SHALL be one sub-module, col_fault_counter, and combinational.
REQ-022 All outputs except operand constants SHALL be registered.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- After reset, job_req=1 and inputs_rdy=1 -> job_ack, STW_test_load_en for 1 cycle, STW_start; STW_complete with result 0 -> fault_map=0, start_fsm, start_matmul LOAD_CYCLES+1 cycles later, done -> job_done.
- TEST_PERIOD=8, 8 clean jobs -> STW runs only on job 0 and job 8.
- Result with bits at (0,1) and (2,1) set -> col_fault_cnt_max=2, err=2, state ERR, later job_req not acked.
- STW_complete withheld -> err=1 after TIMEOUT cycles; matmul_output_done withheld -> err=3.
- rst pulled low during MM_LOAD -> all outputs cleared immediately, no start_matmul, no job_done; next job runs STW again.
- force_test pulsed during MM_RUN -> the next job performs STW_LOAD first.

Source files
------------

// File: rtl/bisr_ctrl_pkg.sv
// Shared types and constants for the BISR session controller: FSM states,
// sticky error codes and the fixed self-test (STW) operand set.
package bisr_ctrl_pkg;

  // The STW pattern is expected = mult_op1 * mult_op2 + add_op.
  localparam logic [63:0] STW_MULT_OP1 = 64'd3;
  localparam logic [63:0] STW_MULT_OP2 = 64'd5;
  localparam logic [63:0] STW_ADD_OP   = 64'd7;
  localparam logic [63:0] STW_EXPECTED = 64'd22;

  typedef enum logic [3:0] {
    IDLE,
    STW_LOAD,
    STW_RUN,
    STW_CHECK,
    MM_FSM,
    MM_LOAD,
    MM_RUN,
    DONE,
    ERR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_STW_TIMEOUT  = 2'd1,
    ERR_UNREPAIRABLE = 2'd2,
    ERR_MM_TIMEOUT   = 2'd3
  } err_code_e;

endpackage

// File: rtl/col_fault_counter.sv
// Combinational per-column popcount of the PE fault map; reports the worst
// column's faulty-PE count.
module col_fault_counter #(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic [ROWS*COLS-1:0]      fault_map,
  output logic [$clog2(ROWS+1)-1:0] max_cnt
);

  localparam int CW = $clog2(ROWS+1);

  logic [CW-1:0] col_cnt;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    max_cnt = '0;
    col_cnt = '0;
    for (int c = 0; c < COLS; c++) begin
      col_cnt = '0;
      for (int r = 0; r < ROWS; r++) begin
        col_cnt = col_cnt + CW'(fault_map[r*COLS+c]);
      end
      if (col_cnt > max_cnt) max_cnt = col_cnt;
    end
  end

endmodule

// File: rtl/bisr_session_ctrl.sv
// Session controller: interleaves periodic built-in self-test (STW) runs with
// matmul jobs, captures the PE fault map and halts on unrepairable faults.
`ifndef ROWS
`define ROWS 4
`endif
`ifndef COLS
`define COLS 4
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module bisr_session_ctrl
  import bisr_ctrl_pkg::*;
#(
  parameter int ROWS        = `ROWS,
  parameter int COLS        = `COLS,
  parameter int WORD_SIZE   = `WORD_SIZE,
  parameter int LOAD_CYCLES = ROWS,
  parameter int TIMEOUT     = 1024,
  parameter int TEST_PERIOD = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_req,
  input  logic                      inputs_rdy,
  input  logic                      force_test,
  output logic                      job_ack,
  output logic                      STW_test_load_en,
  output logic [WORD_SIZE-1:0]      STW_mult_op1,
  output logic [WORD_SIZE-1:0]      STW_mult_op2,
  output logic [WORD_SIZE-1:0]      STW_add_op,
  output logic [WORD_SIZE-1:0]      STW_expected,
  output logic                      STW_start,
  input  logic                      STW_complete,
  input  logic [ROWS*COLS-1:0]      STW_result_mat,
  output logic                      start_fsm,
  output logic                      start_matmul,
  input  logic                      matmul_output_done,
  output logic [ROWS*COLS-1:0]      fault_map,
  output logic [$clog2(ROWS+1)-1:0] col_fault_cnt_max,
  output logic                      busy,
  output logic                      job_done,
  output logic [1:0]                err
);

  localparam int CW      = $clog2(ROWS+1);
  localparam int CNT_MAX = (TIMEOUT > LOAD_CYCLES) ? TIMEOUT : LOAD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX+1);
  localparam int JC_W    = (TEST_PERIOD > 1) ? $clog2(TEST_PERIOD) : 1;

  state_e            state_q, state_d;
  err_code_e         err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [JC_W-1:0]   job_cnt_q;
  logic              force_q;
  logic              captured_q;
  logic [CW-1:0]     col_max;

  assign STW_mult_op1 = STW_MULT_OP1[WORD_SIZE-1:0];
  assign STW_mult_op2 = STW_MULT_OP2[WORD_SIZE-1:0];
  assign STW_add_op   = STW_ADD_OP[WORD_SIZE-1:0];
  assign STW_expected = STW_EXPECTED[WORD_SIZE-1:0];
  assign err          = err_q;

  col_fault_counter #(.ROWS(ROWS), .COLS(COLS)) u_col_cnt (
    .fault_map (fault_map),
    .max_cnt   (col_max)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (job_req && inputs_rdy) begin
          state_d = (force_q || job_cnt_q == '0 || !captured_q) ? STW_LOAD : MM_FSM;
        end
      end
      STW_LOAD: state_d = STW_RUN;
      STW_RUN: begin
        if (STW_complete) begin
          state_d = STW_CHECK;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d = ERR;
          err_d   = ERR_STW_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STW_CHECK: begin
        // One spare weight proxy per column: two or more faults cannot be remapped.
        if (col_max > CW'(1)) begin
          state_d = ERR;
          err_d   = ERR_UNREPAIRABLE;
        end else begin
          state_d = MM_FSM;
        end
      end
      MM_FSM: state_d = MM_LOAD;
      MM_LOAD: begin
        if (cnt_q == CNT_W'(LOAD_CYCLES - 1)) state_d = MM_RUN;
        else cnt_d = cnt_q + 1'b1;
      end
      MM_RUN: begin
        if (matmul_output_done) begin
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d = ERR;
          err_d   = ERR_MM_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Pulses are decoded from the next state so each registered output lines up
  // with the cycle the FSM actually spends in the corresponding state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= IDLE;
      err_q             <= ERR_NONE;
      cnt_q             <= '0;
      job_cnt_q         <= '0;
      force_q           <= 1'b0;
      captured_q        <= 1'b0;
      fault_map         <= '0;
      col_fault_cnt_max <= '0;
      job_ack           <= 1'b0;
      STW_test_load_en  <= 1'b0;
      STW_start         <= 1'b0;
      start_fsm         <= 1'b0;
      start_matmul      <= 1'b0;
      job_done          <= 1'b0;
      busy              <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      state_q          <= state_d;
      err_q            <= err_d;
      cnt_q            <= cnt_d;
      job_ack          <= (state_q == IDLE) && job_req && inputs_rdy;
      STW_test_load_en <= (state_d == STW_LOAD);
      STW_start        <= (state_d == STW_RUN) && (state_q != STW_RUN);
      start_fsm        <= (state_d == MM_FSM);
      start_matmul     <= (state_d == MM_RUN) && (state_q != MM_RUN);
      job_done         <= (state_d == DONE);
      busy             <= (state_d != IDLE);
      force_q          <= force_test ||
                          (force_q && !((state_d == STW_LOAD) && (state_q != STW_LOAD)));
      if (state_q == STW_RUN && STW_complete) begin
        fault_map  <= STW_result_mat;
        captured_q <= 1'b1;
      end
      if (state_q == STW_CHECK) col_fault_cnt_max <= col_max;
      if (state_d == DONE) begin
        job_cnt_q <= (job_cnt_q == JC_W'(TEST_PERIOD - 1)) ? '0 : job_cnt_q + 1'b1;
      end
    end
  end

endmodule
